// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART with transmit and receive FIFOs, a 16x oversampled
// fractional baud divider, 5..9 data bits, 1 or 2 stop bits and sticky
// line-error flags (overrun, framing, parity, break).
// Optional feature macro: UART_PARITY_EN adds a parity bit on TX and checks
// it on RX; without it par_en/par_odd are ignored and parity_err reads 0.
//
// TX state  | meaning
// TX_IDLE   | line marking, waiting for a FIFO entry on a tick
// TX_START  | driving the start bit
// TX_DATA   | shifting data bits out, LSB first
// TX_PARITY | driving the parity bit (UART_PARITY_EN only)
// TX_STOP   | driving one or two stop bits
//
// RX state  | meaning
// RX_HUNT   | waiting for a low level on a tick
// RX_START  | timing to the start-bit midpoint, rejecting glitches
// RX_DATA   | sampling data bits every 16 ticks
// RX_PARITY | sampling the parity bit (UART_PARITY_EN only)
// RX_STOP   | sampling the stop bit, push / flag decisions
// RX_WAIT   | line held low after break or framing error, wait for mark

module uart_fifo #(
  parameter int DATA_BITS = 8,
  parameter int TX_AW     = 4,
  parameter int RX_AW     = 4
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [15:0]          bitperiod,
  input  logic                 stop2,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  output logic                 ready,
  output logic                 txidle,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 avail,
  input  logic                 clr_err,
  output logic                 overrun,
  output logic                 framing,
  output logic                 parity_err,
  output logic                 brk,
  input  logic                 rxd,
  output logic                 txd
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  // ---------------------------------------------------------------- baud tick
  logic [11:0] baud_cnt;
  logic [3:0]  baud_phase;
  logic        tick;

  assign tick = (baud_cnt == 12'd0);

  // Fractional divider: the first frac phases of every 16 get one extra clock
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      baud_cnt   <= 12'd0;
      baud_phase <= 4'd0;
    end else if (tick) begin
      baud_phase <= baud_phase + 4'd1;
      baud_cnt   <= (bitperiod[3:0] > baud_phase) ? bitperiod[15:4]
                                                  : bitperiod[15:4] - 12'd1;
    end else begin
      baud_cnt <= baud_cnt - 12'd1;
    end
  end

  // ------------------------------------------------------------------ TX FIFO
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW:0]       tx_wp, tx_rp;
  logic                 tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                    (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign tx_push  = wr && !tx_full;
  assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];
  assign ready    = !tx_full;

  // TX storage, written only on an accepted push (read only when non-empty)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= din;
  end

  // TX pointers; the shifter pops as it loads a character
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (TX_AW+1)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (TX_AW+1)'(1);
    end
  end

  // -------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
`ifdef UART_PARITY_EN
    , TX_PARITY
`endif
  } tx_state_t;

  tx_state_t            tx_state;
  logic [3:0]           tx_tcnt;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_stop2;
  logic                 tx_second;
  logic                 txd_q;
  logic                 tx_stop_done;
`ifdef UART_PARITY_EN
  logic                 tx_par;
  logic                 tx_par_en;
`endif

  assign tx_stop_done = (tx_state == TX_STOP) && (tx_tcnt == 4'd15) &&
                        (!tx_stop2 || tx_second);
  assign tx_pop = tick && !tx_empty && ((tx_state == TX_IDLE) || tx_stop_done);
  assign txidle = tx_empty && (tx_state == TX_IDLE);
  assign txd    = txd_q;

  // Transmit FSM: loads straight from STOP into START for gapless bursts
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_state  <= TX_IDLE;
      tx_tcnt   <= 4'd0;
      tx_bit    <= 4'd0;
      tx_sh     <= '0;
      tx_stop2  <= 1'b0;
      tx_second <= 1'b0;
      txd_q     <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
      tx_par_en <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state  <= TX_START;
      tx_tcnt   <= 4'd0;
      tx_sh     <= tx_head;
      tx_stop2  <= stop2;
      tx_second <= 1'b0;
      txd_q     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par    <= (^tx_head) ^ par_odd;
      tx_par_en <= par_en;
`endif
    end else if (tick && (tx_state != TX_IDLE)) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_tcnt == 4'd15) begin
        case (tx_state)
          TX_START: begin
            txd_q    <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= 4'd0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              if (tx_par_en) begin
                txd_q    <= tx_par;
                tx_state <= TX_PARITY;
              end else
`endif
              begin
                txd_q    <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              txd_q  <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 4'd1;
            end
          end
`ifdef UART_PARITY_EN
          TX_PARITY: begin
            txd_q    <= 1'b1;
            tx_state <= TX_STOP;
          end
`endif
          TX_STOP: begin
            if (tx_stop2 && !tx_second) tx_second <= 1'b1;
            else                        tx_state  <= TX_IDLE;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ----------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RX_HUNT, RX_START, RX_DATA, RX_STOP, RX_WAIT
`ifdef UART_PARITY_EN
    , RX_PARITY
`endif
  } rx_state_t;

  rx_state_t            rx_state;
  logic [3:0]           rx_tcnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_stop_smp, rx_zero, rx_push;
  logic                 rx_brk_det, rx_frm_det, rx_ovr_det;
  logic                 rx_empty, rx_full, rx_rd, rx_wr;
`ifdef UART_PARITY_EN
  logic                 rx_pbit;
  logic                 rx_pbad;
  logic                 rx_par_det;
`endif

  assign rx_stop_smp = tick && (rx_state == RX_STOP) && (rx_tcnt == 4'd15);
`ifdef UART_PARITY_EN
  assign rx_zero     = (rx_sh == '0) && !rx_pbit;
  assign rx_par_det  = rx_push && rx_pbad;
`else
  assign rx_zero     = (rx_sh == '0);
`endif
  assign rx_brk_det  = rx_stop_smp && !rxd && rx_zero;
  assign rx_frm_det  = rx_stop_smp && !rxd && !rx_zero;
  assign rx_push     = rx_stop_smp && (rxd || !rx_zero);
  assign rx_ovr_det  = rx_push && rx_full && !rx_rd;

  // Receive FSM: start midpoint 8 ticks after detection, then every 16 ticks
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_state <= RX_HUNT;
      rx_tcnt  <= 4'd0;
      rx_bit   <= 4'd0;
      rx_sh    <= '0;
`ifdef UART_PARITY_EN
      rx_pbit  <= 1'b0;
      rx_pbad  <= 1'b0;
`endif
    end else if (tick) begin
      case (rx_state)
        RX_HUNT: begin
          if (!rxd) begin
            rx_state <= RX_START;
            rx_tcnt  <= 4'd0;
`ifdef UART_PARITY_EN
            rx_pbit  <= 1'b0;
            rx_pbad  <= 1'b0;
`endif
          end
        end
        RX_START: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd7) begin
            if (rxd) begin
              rx_state <= RX_HUNT;
            end else begin
              rx_state <= RX_DATA;
              rx_tcnt  <= 4'd0;
              rx_bit   <= 4'd0;
            end
          end
        end
        RX_DATA: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_sh <= {rxd, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state <= par_en ? RX_PARITY : RX_STOP;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_pbit  <= rxd;
            rx_pbad  <= rxd ^ (^rx_sh) ^ par_odd;
            rx_state <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= rxd ? RX_HUNT : RX_WAIT;
        end
        RX_WAIT: begin
          if (rxd) rx_state <= RX_HUNT;
        end
        default: rx_state <= RX_HUNT;
      endcase
    end
  end

  // ------------------------------------------------------------------ RX FIFO
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW:0]       rx_wp, rx_rp;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                    (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
  assign rx_rd    = rd && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_rd);
  assign avail    = !rx_empty;
  assign dout     = rx_mem[rx_rp[RX_AW-1:0]];

  // RX storage is reset so the show-ahead head reads 0 out of reset
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_wp <= '0;
      rx_rp <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_wr) begin
        rx_mem[rx_wp[RX_AW-1:0]] <= rx_sh;
        rx_wp <= rx_wp + (RX_AW+1)'(1);
      end
      if (rx_rd) rx_rp <= rx_rp + (RX_AW+1)'(1);
    end
  end

  // ------------------------------------------------------------- error flags
  // Sticky flags; a set event in the same cycle as clr_err wins
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      overrun <= 1'b0;
      framing <= 1'b0;
      brk     <= 1'b0;
    end else begin
      if (rx_ovr_det)   overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (rx_frm_det)   framing <= 1'b1;
      else if (clr_err) framing <= 1'b0;
      if (rx_brk_det)   brk     <= 1'b1;
      else if (clr_err) brk     <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  // Parity flag, set when a character with a bad parity bit is pushed
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)          parity_err <= 1'b0;
    else if (rx_par_det) parity_err <= 1'b1;
    else if (clr_err)    parity_err <= 1'b0;
  end
`else
  logic unused_par;
  assign unused_par = par_en ^ par_odd;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo (DATA_BITS=8, 16-deep FIFOs).
module tb_uart_fifo;
  localparam int DB = 8;
  localparam int RXBP = 72;  // clocks per bit at bitperiod 16'h0048

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic [15:0]   bitperiod = 16'hFFFF;
  logic          stop2 = 1'b0, par_en = 1'b0, par_odd = 1'b0;
  logic          wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [DB-1:0] din = '0;
  logic          ready, txidle, avail, overrun, framing, parity_err, brk, txd;
  logic [DB-1:0] dout;
  logic          rxd, loop_en = 1'b0, rx_drv = 1'b1;

  int n_pass = 0, n_total = 0;

  assign rxd = loop_en ? txd : rx_drv;

  always #5 clk = ~clk;

  uart_fifo #(.DATA_BITS(DB), .TX_AW(4), .RX_AW(4)) dut (
    .clk(clk), .arstn(arstn), .bitperiod(bitperiod), .stop2(stop2),
    .par_en(par_en), .par_odd(par_odd), .wr(wr), .din(din), .ready(ready),
    .txidle(txidle), .rd(rd), .dout(dout), .avail(avail), .clr_err(clr_err),
    .overrun(overrun), .framing(framing), .parity_err(parity_err), .brk(brk),
    .rxd(rxd), .txd(txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_byte(input logic [DB-1:0] d);
    wr = 1'b1; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_txd(input logic level, input int max, output logic found, output int clocks);
    clocks = 0;
    while (txd !== level && clocks < max) begin
      @(negedge clk);
      clocks++;
    end
    found = (txd === level);
  endtask

  task automatic rx_char(input logic [DB-1:0] d, input logic pen, input logic pbit, input logic stopb);
    rx_drv = 1'b0;
    wait_clks(RXBP);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      wait_clks(RXBP);
    end
    if (pen) begin
      rx_drv = pbit;
      wait_clks(RXBP);
    end
    rx_drv = stopb;
    wait_clks(RXBP);
    rx_drv = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    int          clocks;
    logic [19:0] exp_tx;
    exp_tx = 20'b0101010101_0110001011;

    // reset values
    wait_clks(3);
    arstn = 1'b1;
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ready", ready, 1);
    check("rst_txidle", txidle, 1);
    check("rst_avail", avail, 0);
    check("rst_dout", dout, 0);
    check("rst_overrun", overrun, 0);
    check("rst_framing", framing, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_brk", brk, 0);

    // fill TX FIFO while the slow divider holds off the first load
    wr_byte(8'h00);
    check("txidle_after_wr", txidle, 0);
    for (int i = 1; i < 15; i++) wr_byte(DB'(i));
    check("ready_15", ready, 1);
    wr_byte(8'h0F);
    check("ready_full", ready, 0);
    wr_byte(8'hEE);
    check("ready_full_wr_ignored", ready, 0);
    wait_txd(1'b0, 5000, found, clocks);
    check("slow_start_seen", found, 1);
    wait_clks(10);
    arstn = 1'b0;
    #1;
    check("midchar_rst_txd", txd, 1);
    check("midchar_rst_ready", ready, 1);
    check("midchar_rst_txidle", txidle, 1);

    // back-to-back TX at 54 clocks per tick
    bitperiod = 16'h0360;
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    wr_byte(8'h55);
    wr_byte(8'hA3);
    wait_txd(1'b0, 2000, found, clocks);
    check("tx_start_seen", found, 1);
    wait_txd(1'b1, 2000, found, clocks);
    check("tx_start_len", clocks, 864);
    wait_clks(432);
    for (int k = 1; k < 20; k++) begin
      check($sformatf("tx_bit%0d", k), txd, exp_tx[19-k]);
      if (k < 19) wait_clks(864);
    end
    check("txidle_in_stop", txidle, 0);
    wait_clks(552);
    check("txidle_end", txidle, 1);

    // loopback burst of 16 bytes
    bitperiod = 16'h0048;
    loop_en = 1'b1;
    for (int i = 0; i < 16; i++) wr_byte(DB'(i));
    clocks = 0;
    while (txidle !== 1'b1 && clocks < 20000) begin
      @(negedge clk);
      clocks++;
    end
    check("loop_tx_done", txidle, 1);
    wait_clks(20);
    check("loop_avail", avail, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("loop_dout%0d", i), dout, i);
      rd_pop();
    end
    check("loop_empty", avail, 0);
    check("loop_overrun", overrun, 0);
    check("loop_framing", framing, 0);
    check("loop_brk", brk, 0);
    loop_en = 1'b0;
    wait_clks(50);

    // overrun: 17 characters without reading
    for (int i = 0; i < 17; i++) rx_char(DB'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    wait_clks(10);
    check("ovr_flag", overrun, 1);
    check("ovr_avail", avail, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_dout%0d", i), dout, 8'h40 + i);
      rd_pop();
    end
    check("ovr_17_dropped", avail, 0);
    clear_errors();
    check("ovr_cleared", overrun, 0);

    // false start glitch, then framing error
    rx_drv = 1'b0;
    wait_clks(12);
    rx_drv = 1'b1;
    wait_clks(200);
    check("false_start_avail", avail, 0);
    rx_char(8'h81, 1'b0, 1'b0, 1'b0);
    wait_clks(20);
    check("frm_flag", framing, 1);
    check("frm_brk", brk, 0);
    check("frm_avail", avail, 1);
    check("frm_dout", dout, 8'h81);
    rd_pop();
    clear_errors();
    check("frm_cleared", framing, 0);

    // break: line low for two character times
    rx_drv = 1'b0;
    wait_clks(20 * RXBP);
    rx_drv = 1'b1;
    wait_clks(100);
    check("brk_flag", brk, 1);
    check("brk_avail", avail, 0);
    rx_char(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    check("post_brk_avail", avail, 1);
    check("post_brk_dout", dout, 8'h3C);
    check("post_brk_framing", framing, 0);
    rd_pop();
    clear_errors();
    check("brk_cleared", brk, 0);

`ifdef UART_PARITY_EN
    // odd parity on 8'h07 is 0; inverted parity on RX flags the character
    par_en = 1'b1;
    par_odd = 1'b1;
    wr_byte(8'h07);
    wait_txd(1'b0, 500, found, clocks);
    check("par_start_seen", found, 1);
    wait_clks(RXBP / 2 + RXBP);
    check("par_d0", txd, 1);
    wait_clks(8 * RXBP);
    check("par_bit", txd, 0);
    wait_clks(RXBP);
    check("par_stop", txd, 1);
    wait_clks(200);
    rx_char(8'h07, 1'b1, 1'b1, 1'b1);
    wait_clks(20);
    check("par_err_flag", parity_err, 1);
    check("par_err_avail", avail, 1);
    check("par_err_dout", dout, 8'h07);
    rd_pop();
    clear_errors();
    check("par_err_cleared", parity_err, 0);
    par_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
